// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// apb_master_arbiter : round-robin share of one APB master among NREQ users
// Revision 1.0
// ============================================================================
module apb_master_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                 Hclk,
  input  logic                 Hresetn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_write,
  input  logic [32*NREQ-1:0]   req_addr,
  input  logic [32*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [31:0]          rdata,
  output logic                 busy,
  output logic [31:0]          Paddr,
  output logic                 Pwrite,
  output logic [2:0]           Pselx,
  output logic                 Penable,
  output logic [31:0]          Pwdata,
  input  logic [31:0]          Prdata,
  input  logic                 Pready,
  input  logic                 Pslverr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e             state_q;
  logic [IW-1:0]      rr_ptr_q, gnt_q;
  logic [CW-1:0]      cnt_q;
  logic [NREQ-1:0]    done_q;
  logic               err_q, busy_q, pwrite_q, penable_q;
  logic [31:0]        rdata_q, paddr_q, pwdata_q;
  logic [2:0]         pselx_q;

  logic               gnt_vld_d, gnt_write_d;
  logic [IW-1:0]      gnt_d, rr_ptr_d;
  logic [31:0]        gnt_addr_d, gnt_wdata_d;
  logic [2:0]         sel_d;
  int                 idx_c;

  function automatic logic [2:0] decode(input logic [5:0] top);
    case (top)
      6'b100000: decode = 3'b001;
      6'b100001: decode = 3'b010;
      6'b100010: decode = 3'b100;
      default:   decode = 3'b000;
    endcase
  endfunction

  // Scan from the highest offset down so the last hit is the first requester at/after rr_ptr.
  always_comb begin
    gnt_vld_d   = 1'b0;
    gnt_d       = '0;
    gnt_write_d = 1'b0;
    gnt_addr_d  = '0;
    gnt_wdata_d = '0;
    idx_c       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_c = int'(rr_ptr_q) + k;
      if (idx_c >= NREQ) idx_c = idx_c - NREQ;
      if (req[idx_c]) begin
        gnt_vld_d   = 1'b1;
        gnt_d       = IW'(idx_c);
        gnt_write_d = req_write[idx_c];
        gnt_addr_d  = req_addr[32*idx_c +: 32];
        gnt_wdata_d = req_wdata[32*idx_c +: 32];
      end
    end
    sel_d    = decode(gnt_addr_d[31:26]);
    rr_ptr_d = (gnt_d == IW'(NREQ - 1)) ? '0 : gnt_d + IW'(1);
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      cnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      rdata_q   <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pselx_q   <= '0;
      penable_q <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld_d) begin
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= 1'b1;
            paddr_q  <= gnt_addr_d;
            pwrite_q <= gnt_write_d;
            pwdata_q <= gnt_wdata_d;
            cnt_q    <= '0;
            if (sel_d != 3'b000) begin
              pselx_q <= sel_d;
              state_q <= ST_SETUP;
            end else begin
              done_q[gnt_d] <= 1'b1;
              err_q         <= 1'b1;
              state_q       <= ST_DONE;
            end
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (Pready) begin
            done_q[gnt_q] <= 1'b1;
            err_q         <= Pslverr;
            if (!pwrite_q) rdata_q <= Prdata;
            pselx_q   <= '0;
            penable_q <= 1'b0;
            state_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(TIMEOUT - 1)) begin
              done_q[gnt_q] <= 1'b1;
              err_q         <= 1'b1;
              pselx_q       <= '0;
              penable_q     <= 1'b0;
              state_q       <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign Paddr   = paddr_q;
  assign Pwrite  = pwrite_q;
  assign Pselx   = pselx_q;
  assign Penable = penable_q;
  assign Pwdata  = pwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// tb_apb_master_arbiter : directed + randomized checks against a transfer model
// Revision 1.0
// ============================================================================
module tb_apb_master_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;

  logic              Hclk = 1'b0;
  logic              Hresetn;
  logic [NREQ-1:0]   req, req_write;
  logic [32*NREQ-1:0] req_addr, req_wdata;
  logic [NREQ-1:0]   done;
  logic              err, busy, Pwrite, Penable, Pready, Pslverr;
  logic [31:0]       rdata, Paddr, Pwdata, Prdata;
  logic [2:0]        Pselx;

  int                n_vec = 0;
  int                n_err = 0;
  int                m_rr = 0;
  logic [31:0]       m_rdata = '0;

  apb_master_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .err(err),
    .rdata(rdata), .busy(busy), .Paddr(Paddr), .Pwrite(Pwrite), .Pselx(Pselx),
    .Penable(Penable), .Pwdata(Pwdata), .Prdata(Prdata), .Pready(Pready),
    .Pslverr(Pslverr)
  );

  always #5 Hclk = ~Hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_sel(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a <= 32'h83FF_FFFF) return 3'b001;
    if (a >= 32'h8400_0000 && a <= 32'h87FF_FFFF) return 3'b010;
    if (a >= 32'h8800_0000 && a <= 32'h8BFF_FFFF) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return 32'h8000_0000 + {6'b0, r[25:0]};
      1: return 32'h8400_0000 + {6'b0, r[25:0]};
      2: return 32'h8800_0000 + {6'b0, r[25:0]};
      default: return r;
    endcase
  endfunction

  task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    req_write[i]          = wr;
    req_addr[32*i +: 32]  = a;
    req_wdata[32*i +: 32] = wd;
    req[i]                = 1'b1;
  endtask

  // Entered at the falling edge of an IDLE cycle with the request vector already set.
  task automatic xfer(input int waits, input bit slverr, input logic [31:0] prd, input bit drop);
    int          g;
    logic [2:0]  esel;
    logic [31:0] a;
    bit          tmo;
    g = -1;
    for (int k = 0; k < NREQ; k++)
      if (g < 0 && req[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
    if (g < 0) begin
      n_err++;
      $display("FAIL xfer_setup: observed no pending request expected one");
      return;
    end
    m_rr = (g + 1) % NREQ;
    a    = req_addr[32*g +: 32];
    esel = exp_sel(a);
    tmo  = (waits > TIMEOUT - 1);
    @(negedge Hclk);
    chk("busy_grant", 32'(busy), 32'd1);
    if (esel == 3'b000) begin
      chk("dec_done", 32'(done), 32'd1 << g);
      chk("dec_err", 32'(err), 32'd1);
      chk("dec_psel", 32'(Pselx), 32'd0);
      chk("dec_rdata", rdata, m_rdata);
    end else begin
      chk("setup_psel", 32'(Pselx), 32'(esel));
      chk("setup_pen", 32'(Penable), 32'd0);
      chk("setup_addr", Paddr, a);
      chk("setup_wr", 32'(Pwrite), 32'(req_write[g]));
      chk("setup_wdata", Pwdata, req_wdata[32*g +: 32]);
      chk("setup_done", 32'(done), 32'd0);
      for (int n = 0; n < TIMEOUT; n++) begin
        @(negedge Hclk);
        chk("acc_pen", 32'(Penable), 32'd1);
        chk("acc_psel", 32'(Pselx), 32'(esel));
        chk("acc_done", {31'd0, |done} | {31'd0, err}, 32'd0);
        Pready  = (n == waits);
        Pslverr = (n == waits) ? slverr : 1'($urandom_range(0, 1));
        Prdata  = (n == waits) ? prd : $urandom;
        if (n == waits) break;
      end
      @(negedge Hclk);
      Pready  = 1'b0;
      Pslverr = 1'b0;
      if (!tmo && !req_write[g]) m_rdata = prd;
      chk("done_vec", 32'(done), 32'd1 << g);
      chk("done_err", 32'(err), tmo ? 32'd1 : 32'(slverr));
      chk("done_rdata", rdata, m_rdata);
      chk("done_psel", 32'(Pselx), 32'd0);
      chk("done_pen", 32'(Penable), 32'd0);
      chk("done_busy", 32'(busy), 32'd1);
    end
    if (drop) req[g] = 1'b0;
    @(negedge Hclk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", {31'd0, |done} | {31'd0, err}, 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_paddr"}, Paddr, 32'd0);
    chk({tag, "_pwrite"}, 32'(Pwrite), 32'd0);
    chk({tag, "_psel"}, 32'(Pselx), 32'd0);
    chk({tag, "_pen"}, 32'(Penable), 32'd0);
    chk({tag, "_pwdata"}, Pwdata, 32'd0);
  endtask

  initial begin
    Hresetn = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    Prdata = '0; Pready = 1'b0; Pslverr = 1'b0;
    repeat (3) @(negedge Hclk);
    chk_zero("reset");
    Hresetn = 1'b1;
    @(negedge Hclk);

    // Single write, no wait states
    set_req(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 32'h0, 1'b1);
    // Read with three wait states
    set_req(1, 1'b0, 32'h8400_0004, 32'h0);
    xfer(3, 1'b0, 32'h1234_5678, 1'b1);
    // Both held: alternate grants
    set_req(0, 1'b1, 32'h8000_0100, 32'hA5A5_0000);
    set_req(1, 1'b0, 32'h8800_0200, 32'h0);
    xfer(0, 1'b0, 32'h1111_1111, 1'b0);
    xfer(1, 1'b0, 32'h2222_2222, 1'b0);
    xfer(0, 1'b0, 32'h3333_3333, 1'b0);
    xfer(2, 1'b0, 32'h4444_4444, 1'b0);
    req = '0;
    // Timeout, then Pready on the last allowed cycle
    set_req(0, 1'b0, 32'h8800_0000, 32'h0);
    xfer(TIMEOUT + 5, 1'b0, 32'hFFFF_0000, 1'b1);
    set_req(1, 1'b0, 32'h8000_0040, 32'h0);
    xfer(TIMEOUT - 1, 1'b0, 32'hCAFE_F00D, 1'b1);
    // Decode error and slave error
    set_req(0, 1'b1, 32'h9000_0000, 32'h1);
    xfer(0, 1'b0, 32'h0, 1'b1);
    set_req(1, 1'b0, 32'h8400_0000, 32'h0);
    xfer(1, 1'b1, 32'h5555_AAAA, 1'b1);

    // Reset in the middle of an ACCESS phase
    set_req(0, 1'b0, 32'h8000_0000, 32'h0);
    @(negedge Hclk);
    @(negedge Hclk);
    chk("pre_rst_pen", 32'(Penable), 32'd1);
    Hresetn = 1'b0;
    @(negedge Hclk);
    chk_zero("midrst");
    m_rr = 0; m_rdata = '0;
    Hresetn = 1'b1;
    set_req(1, 1'b1, 32'h8400_0010, 32'h7777_7777);
    xfer(0, 1'b0, 32'h0, 1'b1);
    xfer(0, 1'b0, 32'h0, 1'b1);

    // Randomized traffic with requesters joining independently
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      if (req == '0) set_req(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      case ($urandom_range(0, 7))
        0:       xfer(TIMEOUT + 2, 1'b0, $urandom, 1'b1);
        1:       xfer(TIMEOUT - 1, 1'($urandom_range(0, 1)), $urandom, 1'b1);
        default: xfer(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, 1'b1);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
Shares the single APB master bus between NREQ independent requesters, such as the AHB bridge write/read paths and a debug/config port. It arbitrates round-robin, decodes the slave select, and runs the APB SETUP/ACCESS protocol with PREADY wait states. It completes each transfer with a one-cycle done pulse carrying read data and error status. A transfer terminates with an error if the slave stalls past TIMEOUT.

Parameters:
NREQ, 2, number of requesters (2..4).
TIMEOUT, 16, maximum ACCESS cycles with Pready low before forced error completion (>=2).

Ports:
Hclk  in  1  clock; all logic on rising edge.
Hresetn  in  1  reset; synchronous, active-low.
req  in  NREQ  per-requester transfer request; held high with fields stable until own done.
req_write  in  NREQ  1=write, 0=read, per requester.
req_addr  in  32*NREQ  flattened addresses; requester i at [32*i+31:32*i].
req_wdata  in  32*NREQ  flattened write data.
done  out  NREQ  one-cycle completion pulse, one-hot to granted requester.
err  out  1  valid with done: 1=decode error, Pslverr or timeout.
rdata  out  32  valid with done on reads.
busy  out  1  high from grant until end of DONE cycle.
Paddr  out  32  APB address.
Pwrite  out  1  APB direction.
Pselx  out  3  one-hot APB slave select.
Penable  out  1  APB enable.
Pwdata  out  32  APB write data.
Prdata  in  32  APB read data.
Pready  in  1  APB ready.
Pslverr  in  1  APB slave error.

Behaviour:
- All outputs registered.
- Reset, applied at any time including mid-transfer: all outputs 0, state IDLE, rr_ptr=0, timeout counter 0. An abandoned transfer gets no done.
- Address decode:
  - 0x8000_0000-0x83FF_FFFF -> Pselx=001.
  - 0x8400_0000-0x87FF_FFFF -> Pselx=010.
  - 0x8800_0000-0x8BFF_FFFF -> Pselx=100.
  - Any other address is a decode error.
- State IDLE:
  - Outputs: Pselx=0, Penable=0, busy=0.
  - If any req is high, grant the first requester at or after rr_ptr (modulo NREQ).
  - On grant: latch its addr, wdata and write; set rr_ptr = gnt+1 mod NREQ; busy=1.
  - Valid decode -> SETUP. Decode error -> DONE with err=1; Pselx never asserted.
- State SETUP, exactly 1 cycle:
  - Outputs: Pselx=decode, Penable=0, Paddr/Pwrite/Pwdata = latched values.
  - -> ACCESS.
- State ACCESS:
  - Outputs: Penable=1; Pselx/Paddr/Pwrite/Pwdata unchanged from SETUP.
  - The counter increments each cycle Pready=0.
  - Pready=1 -> DONE with err=Pslverr; on a read, rdata=Prdata.
  - Pready=0 with count==TIMEOUT-1 -> DONE with err=1; rdata unchanged.
  - Pready=1 on the timeout cycle is a normal completion.
- State DONE, exactly 1 cycle:
  - Outputs: done[gnt]=1, Pselx=0, Penable=0, busy=1.
  - No arbitration occurs this cycle, so the finishing requester can drop req.
  - -> IDLE.
- Latency, with req seen at edge 0 and Pready=1: SETUP in cycle 1, ACCESS in cycle 2, done in cycle 3, next grant evaluated in cycle 4. Minimum 4-cycle issue interval.
- Decode error: done in cycle 1 after grant.
- rdata updates only on read completion and holds otherwise. err is 0 whenever done=0.
- Simultaneous requests are served in round-robin order; no requester waits more than NREQ-1 transfers.
- A req deasserted before its done is a protocol violation; the latched transfer still completes.

Test Plan:
- Single write, req[0], addr 0x8000_0010, wdata 0xDEAD_BEEF, Pready=1 -> cycle 1: Pselx=001, Penable=0, Pwrite=1; cycle 2: Penable=1; cycle 3: done=01, err=0.
- Read, req[1], addr 0x8400_0004, Pready low 3 cycles, then Prdata=0x1234_5678 -> ACCESS lasts 4 cycles; done=10, rdata=0x1234_5678, err=0.
- req=11 held continuously, rr_ptr=0 -> grants alternate 0,1,0,1; each done is one-hot; no back-to-back grant to the same requester.
- Timeout: Pready stuck at 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, then done with err=1; Pselx=0 in the DONE cycle.
- Decode error, addr 0x9000_0000 -> Pselx stays 0; done one cycle after grant with err=1. Pslverr=1 on a valid access -> err=1.
- Hresetn low during ACCESS -> next cycle all outputs 0; no done pulse; the next request arbitrates from rr_ptr=0.
